// File: rtl/param_stack_unit.sv
// Parametrised LIFO stack with registered top/next-of-stack, replace, sticky errors.
// Optional DUP/SWAP primitives enabled by defining STACK_DUP_SWAP_EN.
module param_stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             dup,
    input  logic             swap,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] nos,
    output logic [WIDTH-1:0] popped,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [WIDTH-1:0] popped_q, popped_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             set_ovf, set_unf;
    logic             is_empty, is_full, has3;
    logic [AW-1:0]    a0, am1, am3;

    logic             we0;
    logic [AW-1:0]    wa0;
    logic [WIDTH-1:0] wd0;

    logic op_push, op_rep, op_pop;

    // Pointer arithmetic wraps modulo 2**AW; only in-range indices are ever used.
    assign a0  = count_q[AW-1:0];
    assign am1 = a0 - AW'(1);
    assign am3 = a0 - AW'(3);

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign has3     = (count_q >= CW'(3));

    assign op_push = push & (~pop | is_empty);
    assign op_rep  = push & pop & ~is_empty;
    assign op_pop  = pop & ~push;

`ifdef STACK_DUP_SWAP_EN
    logic             op_dup, op_swap, has2;
    logic             we1;
    logic [AW-1:0]    wa1;
    logic [WIDTH-1:0] wd1;
    logic [AW-1:0]    am2;

    assign am2     = a0 - AW'(2);
    assign has2    = (count_q >= CW'(2));
    assign op_dup  = ~push & ~pop & dup;
    assign op_swap = ~push & ~pop & ~dup & swap;
`else
    logic unused_dup_swap;
    assign unused_dup_swap = dup ^ swap;
`endif

    always_comb begin
        count_d  = count_q;
        dout_d   = dout_q;
        nos_d    = nos_q;
        popped_d = popped_q;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        we0      = 1'b0;
        wa0      = a0;
        wd0      = d_in;
`ifdef STACK_DUP_SWAP_EN
        we1      = 1'b0;
        wa1      = am2;
        wd1      = dout_q;
`endif
        unique case (1'b1)
            op_push: begin
                if (is_full) begin
                    set_ovf = 1'b1;
                end else begin
                    we0     = 1'b1;
                    count_d = count_q + CW'(1);
                    dout_d  = d_in;
                    nos_d   = dout_q;
                end
            end
            op_rep: begin
                we0      = 1'b1;
                wa0      = am1;
                popped_d = dout_q;
                dout_d   = d_in;
            end
            op_pop: begin
                if (is_empty) begin
                    set_unf = 1'b1;
                end else begin
                    popped_d = dout_q;
                    count_d  = count_q - CW'(1);
                    dout_d   = nos_q;
                    nos_d    = has3 ? mem[am3] : '0;
                end
            end
`ifdef STACK_DUP_SWAP_EN
            op_dup: begin
                if (is_empty) begin
                    set_unf = 1'b1;
                end else if (is_full) begin
                    set_ovf = 1'b1;
                end else begin
                    we0     = 1'b1;
                    wd0     = dout_q;
                    count_d = count_q + CW'(1);
                    nos_d   = dout_q;
                end
            end
            op_swap: begin
                if (!has2) begin
                    set_unf = 1'b1;
                end else begin
                    we0    = 1'b1;
                    wa0    = am1;
                    wd0    = nos_q;
                    we1    = 1'b1;
                    dout_d = nos_q;
                    nos_d  = dout_q;
                end
            end
`endif
            default: ;
        endcase
    end

    // A new error in the same cycle wins over clr_err.
    assign ovf_d = set_ovf | (ovf_q & ~clr_err);
    assign unf_d = set_unf | (unf_q & ~clr_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            dout_q   <= '0;
            nos_q    <= '0;
            popped_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            dout_q   <= dout_d;
            nos_q    <= nos_d;
            popped_q <= popped_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
`ifdef STACK_DUP_SWAP_EN
        if (we1) mem[wa1] <= wd1;
`endif
    end

    assign d_out     = dout_q;
    assign nos       = nos_q;
    assign popped    = popped_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack_unit.sv
// Bench for param_stack_unit: directed scenarios plus random ops vs a queue model.
// Dup/swap expectations follow STACK_DUP_SWAP_EN as compiled.
module tb_param_stack_unit;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          push, pop, dup, swap, clr_err;
    logic [W-1:0]  d_in;
    logic [W-1:0]  d_out, nos, popped;
    logic [CW-1:0] count;
    logic          empty, full, overflow, underflow;

    param_stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .push(push), .pop(pop), .dup(dup), .swap(swap),
        .clr_err(clr_err), .d_in(d_in),
        .d_out(d_out), .nos(nos), .popped(popped),
        .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int       q[$];
    int       m_pop = 0;
    bit       m_ovf = 0;
    bit       m_unf = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pop = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step(bit p, bit po, bit du, bit sw, bit c, int din);
        bit so = 0;
        bit su = 0;
        int t;
        if (p && po && q.size() > 0) begin
            m_pop = q[q.size()-1];
            q[q.size()-1] = din;
        end else if (p) begin
            if (q.size() == D) so = 1;
            else q.push_back(din);
        end else if (po) begin
            if (q.size() == 0) su = 1;
            else m_pop = q.pop_back();
        end
`ifdef STACK_DUP_SWAP_EN
        else if (du) begin
            if (q.size() == 0) su = 1;
            else if (q.size() == D) so = 1;
            else q.push_back(q[q.size()-1]);
        end else if (sw) begin
            if (q.size() < 2) su = 1;
            else begin
                t = q[q.size()-1];
                q[q.size()-1] = q[q.size()-2];
                q[q.size()-2] = t;
            end
        end
`else
        if (du || sw) t = 0;
`endif
        m_ovf = so | (m_ovf & !c);
        m_unf = su | (m_unf & !c);
    endtask

    task automatic check_all(string tag);
        int n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".d_out"}, 32'(d_out), (n > 0) ? 32'(q[n-1]) : 32'd0);
        chk({tag, ".nos"}, 32'(nos), (n > 1) ? 32'(q[n-2]) : 32'd0);
        chk({tag, ".popped"}, 32'(popped), 32'(m_pop));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == D));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic step(string tag, bit p, bit po, bit du, bit sw,
                        bit c, logic [W-1:0] din);
        @(negedge clk);
        push = p; pop = po; dup = du; swap = sw;
        clr_err = c; d_in = din;
        @(posedge clk);
        #1;
        model_step(p, po, du, sw, c, int'(din));
        check_all(tag);
        push = 0; pop = 0; dup = 0; swap = 0; clr_err = 0;
    endtask

    logic [W-1:0] seq [4];

    initial begin
        rst = 1; push = 0; pop = 0; dup = 0; swap = 0;
        clr_err = 0; d_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        check_all("reset");

        step("s1p", 1, 0, 0, 0, 0, 8'h11);
        step("s1p", 1, 0, 0, 0, 0, 8'h22);
        step("s1p", 1, 0, 0, 0, 0, 8'h33);
        step("s1p", 1, 0, 0, 0, 0, 8'h44);
        chk("s1_full", 32'(full), 32'd1);
        step("s1ovf", 1, 0, 0, 0, 0, 8'h55);
        chk("s1_ovf_top", 32'(d_out), 32'h44);

        seq[0] = 8'h44; seq[1] = 8'h33; seq[2] = 8'h22; seq[3] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            step("s2pop", 0, 1, 0, 0, 0, 8'h00);
            chk("s2_popseq", 32'(popped), 32'(seq[i]));
        end
        step("s2unf", 0, 1, 0, 0, 0, 8'h00);
        chk("s2_unf_popped", 32'(popped), 32'h11);

        step("s5clr_ill", 0, 1, 0, 0, 1, 8'h00);
        chk("s5_sticky", 32'(underflow), 32'd1);
        step("s5clr", 0, 0, 0, 0, 1, 8'h00);
        chk("s5_cleared", 32'(underflow), 32'd0);
        step("s5clr_ovf", 0, 0, 0, 0, 1, 8'h00);

        step("s3p", 1, 0, 0, 0, 0, 8'h0A);
        step("s3p", 1, 0, 0, 0, 0, 8'h0B);
        step("s3rep", 1, 1, 0, 0, 0, 8'h7F);
        chk("s3_popped", 32'(popped), 32'h0B);
        chk("s3_nos", 32'(nos), 32'h0A);
        step("s3pop", 0, 1, 0, 0, 0, 8'h00);
        step("s3pop", 0, 1, 0, 0, 0, 8'h00);
        step("s3rep_empty", 1, 1, 0, 0, 0, 8'h66);
        step("s3pop", 0, 1, 0, 0, 0, 8'h00);

        step("s4p", 1, 0, 0, 0, 0, 8'h05);
        step("s4p", 1, 0, 0, 0, 0, 8'h09);
        step("s4swap", 0, 0, 0, 1, 0, 8'h00);
        step("s4dup", 0, 0, 1, 0, 0, 8'h00);
        step("s4pop", 0, 1, 0, 0, 0, 8'h00);
        step("s4pop", 0, 1, 0, 0, 0, 8'h00);
        step("s4pop", 0, 1, 0, 0, 0, 8'h00);
        step("s4dup_empty", 0, 0, 1, 0, 0, 8'h00);
        step("s4swap_empty", 0, 0, 0, 1, 1, 8'h00);
`ifdef STACK_DUP_SWAP_EN
        chk("s4_swap_unf", 32'(underflow), 32'd1);
`else
        chk("s4_noerr", 32'(underflow), 32'd0);
`endif

        step("s6p", 1, 0, 0, 0, 0, 8'hA1);
        step("s6p", 1, 0, 0, 0, 0, 8'hA2);
        @(negedge clk);
        #2 rst = 1;
        #1;
        model_reset();
        check_all("s6async");
        @(negedge clk);
        rst = 0;
        step("s6p", 1, 0, 0, 0, 0, 8'hC3);
        chk("s6_top", 32'(d_out), 32'hC3);

        for (int i = 0; i < 800; i++) begin
            step("rnd",
                 ($urandom % 3) == 0, ($urandom % 3) == 0,
                 ($urandom % 4) == 0, ($urandom % 4) == 0,
                 ($urandom % 10) == 0, W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
